// File: rtl/lp_fb_writer.sv
// Framebuffer writer for a dual-scan LED panel: read-modify-write of single pixels
// into packed top/bottom-half words, plus a full-buffer colour fill.
module lp_fb_writer #(
    parameter int NUM_COLS  = 64,
    parameter int NUM_ROWS  = 64,
    parameter int BIT_DEPTH = 4,
    localparam int XW = $clog2(NUM_COLS),
    localparam int YW = $clog2(NUM_ROWS),
    localparam int PW = 3 * BIT_DEPTH,
    localparam int AW = XW + YW - 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XW-1:0]   req_x,
    input  logic [YW-1:0]   req_y,
    input  logic [PW-1:0]   req_color,
    input  logic            clr_start,
    input  logic [PW-1:0]   clr_color,
    output logic [AW-1:0]   mem_addr,
    output logic            mem_rd,
    input  logic [2*PW-1:0] mem_rdata,
    output logic            mem_we,
    output logic [2*PW-1:0] mem_wdata,
    output logic            busy,
    output logic            done
);

    typedef enum logic [2:0] {IDLE, RD, WR, CLR, FIN} state_t;

    localparam logic [AW-1:0] ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] ADDR_LAST = {AW{1'b1}};

    state_t          state_r, state_s;
    logic [PW-1:0]   color_r, color_s;
    logic            half_r, half_s;
    logic [AW-1:0]   addr_s;
    logic [2*PW-1:0] wdata_s;
    logic            rd_s, we_s, done_s;

    // Replace the selected half of a packed word with a new pixel.
    function automatic logic [2*PW-1:0] merge_half(input logic [2*PW-1:0] word,
                                                   input logic [PW-1:0]   px,
                                                   input logic            bottom);
        if (bottom) begin
            merge_half = {word[2*PW-1:PW], px};
        end else begin
            merge_half = {px, word[PW-1:0]};
        end
    endfunction

    // Next-state and next-output logic; mem_addr doubles as the clear counter.
    always_comb begin
        state_s = state_r;
        color_s = color_r;
        half_s  = half_r;
        addr_s  = mem_addr;
        wdata_s = mem_wdata;
        rd_s    = 1'b0;
        we_s    = 1'b0;
        done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (clr_start) begin
                    state_s = CLR;
                    we_s    = 1'b1;
                    addr_s  = {AW{1'b0}};
                    wdata_s = {clr_color, clr_color};
                end else if (req_valid && req_ready) begin
                    state_s = RD;
                    rd_s    = 1'b1;
                    addr_s  = {req_y[YW-2:0], req_x};
                    color_s = req_color;
                    half_s  = req_y[YW-1];
                end else begin
                    state_s = IDLE;
                end
            end
            // Read data is sampled on the edge that closes the read-strobe cycle.
            RD: begin
                state_s = WR;
                we_s    = 1'b1;
                wdata_s = merge_half(mem_rdata, color_r, half_r);
            end
            WR: begin
                state_s = FIN;
                done_s  = 1'b1;
            end
            CLR: begin
                if (mem_addr == ADDR_LAST) begin
                    state_s = FIN;
                    done_s  = 1'b1;
                end else begin
                    we_s   = 1'b1;
                    addr_s = mem_addr + ADDR_ONE;
                end
            end
            FIN: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any memory access at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            color_r   <= {PW{1'b0}};
            half_r    <= 1'b0;
            mem_addr  <= {AW{1'b0}};
            mem_wdata <= {(2*PW){1'b0}};
            mem_rd    <= 1'b0;
            mem_we    <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b0;
        end else begin
            state_r   <= state_s;
            color_r   <= color_s;
            half_r    <= half_s;
            mem_addr  <= addr_s;
            mem_wdata <= wdata_s;
            mem_rd    <= rd_s;
            mem_we    <= we_s;
            done      <= done_s;
            busy      <= (state_s != IDLE);
            req_ready <= (state_s == IDLE);
        end
    end

endmodule

// File: tb/tb_lp_fb_writer.sv
// Directed bench for lp_fb_writer with a behavioural framebuffer and a write scoreboard.
module tb_lp_fb_writer;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_x;
    logic [5:0]  req_y;
    logic [11:0] req_color;
    logic        clr_start;
    logic [11:0] clr_color;
    logic [10:0] mem_addr;
    logic        mem_rd;
    logic [23:0] mem_rdata;
    logic        mem_we;
    logic [23:0] mem_wdata;
    logic        busy;
    logic        done;

    logic        pl_en;
    logic [10:0] pl_addr;
    logic [23:0] pl_data;
    logic [23:0] mem [0:2047];
    logic [34:0] sb [$];
    int          n_checks;
    int          n_fail;
    bit          overlap;

    lp_fb_writer dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_color (req_color),
        .clr_start (clr_start),
        .clr_color (clr_color),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_rdata (mem_rdata),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Framebuffer model: read data visible during the read-strobe cycle.
    assign mem_rdata = mem_rd ? mem[mem_addr] : 24'h000000;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every write strobe is matched against the next expected write.
    always @(negedge clk) begin
        if (mem_rd && mem_we) overlap = 1'b1;
        if (mem_we) begin
            chk("wr_pending", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                logic [34:0] e;
                e = sb.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(e[34:24]));
                chk("wr_data", 32'(mem_wdata), 32'(e[23:0]));
            end
        end
    end

    task automatic pixel(input logic [5:0] x, input logic [5:0] y, input logic [11:0] c,
                         input logic [23:0] exp_w, input bit inj);
        logic [10:0] a;
        a = {y[4:0], x};
        req_valid = 1'b1; req_x = x; req_y = y; req_color = c;
        sb.push_back({a, exp_w});
        @(negedge clk);
        req_valid = 1'b0;
        if (inj) begin
            clr_start = 1'b1; clr_color = 12'hBAD;
            req_valid = 1'b1; req_x = 6'd7; req_y = 6'd7; req_color = 12'hBAD;
        end
        chk("px_rd", 32'(mem_rd), 32'd1);
        chk("px_rd_addr", 32'(mem_addr), 32'(a));
        chk("px_busy", 32'(busy), 32'd1);
        chk("px_not_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        clr_start = 1'b0; req_valid = 1'b0;
        chk("px_we", 32'(mem_we), 32'd1);
        chk("px_rd_off", 32'(mem_rd), 32'd0);
        @(negedge clk);
        chk("px_done", 32'(done), 32'd1);
        chk("px_we_off", 32'(mem_we), 32'd0);
        @(negedge clk);
        chk("px_done_off", 32'(done), 32'd0);
        chk("px_ready", 32'(req_ready), 32'd1);
        chk("px_idle", 32'(busy), 32'd0);
    endtask

    task automatic run_clear(input logic [11:0] c);
        int k;
        bit ready_hi;
        bit rd_seen;
        clr_start = 1'b1; clr_color = c;
        for (int i = 0; i < 2048; i++) sb.push_back({11'(i), c, c});
        k = 0; ready_hi = 1'b0; rd_seen = 1'b0;
        while (k < 2100) begin
            @(negedge clk);
            clr_start = 1'b0;
            k++;
            if (req_ready) ready_hi = 1'b1;
            if (mem_rd) rd_seen = 1'b1;
            if (done) break;
        end
        chk("clr_len", 32'(k), 32'd2049);
        chk("clr_ready_low", 32'(ready_hi), 32'd0);
        chk("clr_no_reads", 32'(rd_seen), 32'd0);
        @(negedge clk);
        chk("clr_done_once", 32'(done), 32'd0);
        chk("clr_ready_after", 32'(req_ready), 32'd1);
        chk("clr_sb_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int k;
        n_checks = 0; n_fail = 0; overlap = 1'b0;
        req_valid = 1'b0; req_x = 6'd0; req_y = 6'd0; req_color = 12'h000;
        clr_start = 1'b0; clr_color = 12'h000;
        pl_en = 1'b0; pl_addr = 11'd0; pl_data = 24'h000000;
        rst = 1'b1;
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_rd", 32'(mem_rd), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);

        pl_en = 1'b1; pl_addr = 11'h041; pl_data = 24'hABC123;
        @(negedge clk);
        pl_addr = 11'h7FF; pl_data = 24'h111222;
        @(negedge clk);
        pl_en = 1'b0;
        rst = 1'b1;
        #1 chk("rel_ready_low", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("rel_ready", 32'(req_ready), 32'd1);

        pixel(6'd1, 6'd1, 12'hF00, 24'hF00123, 1'b0);
        pixel(6'd63, 6'd63, 12'h0F0, 24'h1110F0, 1'b0);

        run_clear(12'h00F);
        chk("clr_word_041", 32'(mem[11'h041]), 32'h00F00F);

        pixel(6'd5, 6'd2, 12'h123, 24'h12300F, 1'b0);
        pixel(6'd5, 6'd34, 12'h456, 24'h123456, 1'b0);
        chk("same_word", 32'(mem[11'h085]), 32'h123456);

        req_valid = 1'b1; req_x = 6'd3; req_y = 6'd40; req_color = 12'h777;
        run_clear(12'hA5A);
        sb.push_back({11'h203, 24'hA5A777});
        @(negedge clk);
        req_valid = 1'b0;
        chk("both_rd", 32'(mem_rd), 32'd1);
        chk("both_rd_addr", 32'(mem_addr), 32'h203);
        repeat (3) @(negedge clk);
        chk("both_word", 32'(mem[11'h203]), 32'hA5A777);

        pixel(6'd0, 6'd0, 12'hFFF, 24'hFFFA5A, 1'b1);
        repeat (3) @(negedge clk);
        chk("ign_idle", 32'(busy), 32'd0);
        chk("ign_sb_empty", 32'(sb.size()), 32'd0);
        chk("ign_word", 32'(mem[11'h000]), 32'hFFFA5A);

        clr_start = 1'b1; clr_color = 12'h0F0;
        for (int i = 0; i <= 100; i++) sb.push_back({11'(i), 24'h0F00F0});
        k = 0;
        while (k < 200) begin
            @(negedge clk);
            clr_start = 1'b0;
            k++;
            if (mem_we && mem_addr == 11'd100) break;
        end
        chk("mid_reach_100", 32'(k), 32'd101);
        #2 rst = 1'b0;
        #1;
        chk("mid_we_async", 32'(mem_we), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_addr", 32'(mem_addr), 32'd0);
        chk("mid_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("mid_w99", 32'(mem[11'd99]), 32'h0F00F0);
        chk("mid_w100", 32'(mem[11'd100]), 32'hA5AA5A);
        chk("mid_w2047", 32'(mem[11'd2047]), 32'hA5AA5A);
        chk("mid_sb_empty", 32'(sb.size()), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_ready_after", 32'(req_ready), 32'd1);
        chk("mid_no_write", 32'(mem[11'd100]), 32'hA5AA5A);

        chk("rd_we_exclusive", 32'(overlap), 32'd0);
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
